// File: rtl/rescale_neighbor_fetch.sv
// Two-row stamp buffer that streams RGB565 rows in and fetches a 2x2 neighborhood.
// Define RESCALE_NF_EDGE_CLAMP_EN to clamp out-of-range columns instead of zeroing them.
module rescale_neighbor_fetch #(
    parameter int STAMP_W = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    input  logic        frame_start,
    input  logic        fill_req,
    input  logic [8:0]  row_to_wait,
    output logic        fill_done,
    input  logic        fetch_req,
    input  logic [10:0] neighbor_offset,
    output logic [15:0] neighbor0,
    output logic [15:0] neighbor1,
    output logic [15:0] neighbor2,
    output logic [15:0] neighbor3,
    output logic        neighbor_valid,
    output logic        busy,
    output logic [1:0]  rows_loaded,
    output logic        fetch_err,
    output logic        row_err
);
    localparam int AW = (STAMP_W > 1) ? $clog2(STAMP_W) : 1;
    localparam logic [AW-1:0] LAST = AW'(STAMP_W - 1);
`ifdef RESCALE_NF_EDGE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SKIP, FILL, READY, FETCH1, FETCH2} state_t;

    state_t        state;
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic          ptr;
    logic [AW-1:0] col;
    logic [8:0]    rows_left;
    logic [AW-1:0] c0, c1;
    logic          c0_ok, c1_ok;
    logic [15:0]   mem [2][STAMP_W];

    logic          beat, is_last, fetch_ok;
    logic          neg, in0, in1, range_bad;
    logic [11:0]   off0, off1;
    logic [AW-1:0] a0, a1;

    // Async assert, two-flop synchronised release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign s_tready = (state == SKIP) || (state == FILL);
    assign busy     = !((state == IDLE) || (state == READY));
    assign beat     = s_tvalid && s_tready;
    assign is_last  = (col == LAST);
    assign fetch_ok = (state == READY) && (rows_loaded == 2'd2) && !fill_req;

    // Offset 0x7FF is column -1; its right neighbor is column 0.
    always_comb begin
        neg       = (neighbor_offset == 11'h7FF);
        off0      = {1'b0, neighbor_offset};
        off1      = off0 + 12'd1;
        in0       = !neg && (off0 < 12'(STAMP_W));
        in1       = neg || (off1 < 12'(STAMP_W));
        a0        = in0 ? off0[AW-1:0] : (neg ? '0 : LAST);
        a1        = neg ? '0 : (in1 ? off1[AW-1:0] : LAST);
        range_bad = !CLAMP && !(in0 && in1);
    end

    always_ff @(posedge clock) begin
        if (state == FILL && beat && !frame_start)
            mem[~ptr][col] <= s_tdata;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            col            <= '0;
            rows_left      <= '0;
            c0             <= '0;
            c1             <= '0;
            c0_ok          <= 1'b0;
            c1_ok          <= 1'b0;
            rows_loaded    <= 2'd0;
            fill_done      <= 1'b0;
            neighbor_valid <= 1'b0;
            fetch_err      <= 1'b0;
            row_err        <= 1'b0;
            neighbor0      <= '0;
            neighbor1      <= '0;
            neighbor2      <= '0;
            neighbor3      <= '0;
        end else begin
            fill_done      <= 1'b0;
            neighbor_valid <= 1'b0;
            if (beat && (s_tlast != is_last))
                row_err <= 1'b1;
            if (!frame_start && fetch_req && (!fetch_ok || range_bad))
                fetch_err <= 1'b1;
            if (frame_start) begin
                state       <= IDLE;
                rows_loaded <= 2'd0;
            end else begin
                unique case (state)
                    IDLE, READY: begin
                        if (fill_req) begin
                            col       <= '0;
                            rows_left <= row_to_wait;
                            state     <= (row_to_wait != 9'd0) ? SKIP : FILL;
                        end else if (fetch_ok && fetch_req) begin
                            c0    <= a0;
                            c1    <= a1;
                            c0_ok <= CLAMP || in0;
                            c1_ok <= CLAMP || in1;
                            state <= FETCH1;
                        end
                    end
                    SKIP: begin
                        if (beat) begin
                            col <= is_last ? '0 : col + AW'(1);
                            if (is_last) begin
                                rows_left <= rows_left - 9'd1;
                                if (rows_left == 9'd1) state <= FILL;
                            end
                        end
                    end
                    FILL: begin
                        if (beat) begin
                            col <= is_last ? '0 : col + AW'(1);
                            if (is_last) begin
                                ptr         <= ~ptr;
                                rows_loaded <= (rows_loaded == 2'd2) ? 2'd2 : rows_loaded + 2'd1;
                                fill_done   <= 1'b1;
                                state       <= READY;
                            end
                        end
                    end
                    FETCH1: begin
                        neighbor0      <= c0_ok ? mem[~ptr][c0] : '0;
                        neighbor1      <= c1_ok ? mem[~ptr][c1] : '0;
                        neighbor2      <= c0_ok ? mem[ptr][c0] : '0;
                        neighbor3      <= c1_ok ? mem[ptr][c1] : '0;
                        neighbor_valid <= 1'b1;
                        state          <= FETCH2;
                    end
                    FETCH2: state <= READY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rescale_neighbor_fetch.sv
// Directed bench for rescale_neighbor_fetch: fills, fetches, edges, errors, resets.
// Expected neighbor sets go through a scoreboard queue.
module tb_rescale_neighbor_fetch;
    localparam int SW = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic        frame_start, fill_req, fill_done;
    logic [8:0]  row_to_wait;
    logic        fetch_req;
    logic [10:0] neighbor_offset;
    logic [15:0] neighbor0, neighbor1, neighbor2, neighbor3;
    logic        neighbor_valid, busy, fetch_err, row_err;
    logic [1:0]  rows_loaded;

    int n_assert = 0;
    int n_fail = 0;
    logic [63:0] sb[$];

    rescale_neighbor_fetch #(.STAMP_W(SW)) dut (
        .clock(clock), .reset_n(reset_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .frame_start(frame_start), .fill_req(fill_req), .row_to_wait(row_to_wait),
        .fill_done(fill_done), .fetch_req(fetch_req), .neighbor_offset(neighbor_offset),
        .neighbor0(neighbor0), .neighbor1(neighbor1), .neighbor2(neighbor2),
        .neighbor3(neighbor3), .neighbor_valid(neighbor_valid), .busy(busy),
        .rows_loaded(rows_loaded), .fetch_err(fetch_err), .row_err(row_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_row(input logic [8:0] rtw, input int nbeats,
                            input logic [15:0] base, input string tag);
        @(negedge clock);
        fill_req    = 1'b1;
        row_to_wait = rtw;
        @(negedge clock);
        fill_req = 1'b0;
        chk($sformatf("%s_tready", tag), 64'(s_tready), 64'd1);
        for (int i = 0; i < nbeats; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = base + 16'(i);
            s_tlast  = ((i % SW) == SW - 1);
            @(negedge clock);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk($sformatf("%s_done", tag), 64'(fill_done), 64'd1);
        @(negedge clock);
        chk($sformatf("%s_done_pulse", tag), 64'(fill_done), 64'd0);
    endtask

    task automatic do_fetch(input logic [10:0] off, input logic [63:0] exp, input string tag);
        logic [63:0] want;
        @(negedge clock);
        fetch_req       = 1'b1;
        neighbor_offset = off;
        sb.push_back(exp);
        @(negedge clock);
        fetch_req = 1'b0;
        chk($sformatf("%s_early", tag), 64'(neighbor_valid), 64'd0);
        @(negedge clock);
        chk($sformatf("%s_valid", tag), 64'(neighbor_valid), 64'd1);
        want = sb.pop_front();
        chk(tag, {neighbor0, neighbor1, neighbor2, neighbor3}, want);
        @(negedge clock);
        chk($sformatf("%s_pulse", tag), 64'(neighbor_valid), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        frame_start = 1'b0; fill_req = 1'b0; row_to_wait = '0;
        fetch_req = 1'b0; neighbor_offset = '0;
        repeat (4) @(negedge clock);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rows", 64'(rows_loaded), 64'd0);
        chk("rst_errs", {62'd0, fetch_err, row_err}, 64'd0);
        chk("rst_pulses", {62'd0, fill_done, neighbor_valid}, 64'd0);
        chk("rst_nb", {neighbor0, neighbor1, neighbor2, neighbor3}, 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        fill_row(9'd0, SW, 16'h0000, "fill0");
        chk("rows1", 64'(rows_loaded), 64'd1);
        fill_row(9'd0, SW, 16'h0008, "fill1");
        chk("rows2", 64'(rows_loaded), 64'd2);

        do_fetch(11'd3, 64'h0003_0004_000B_000C, "fetch3");
        do_fetch(11'd0, 64'h0000_0001_0008_0009, "fetch0");
        do_fetch(11'd6, 64'h0006_0007_000E_000F, "fetch6");
        chk("no_ferr", 64'(fetch_err), 64'd0);

        fill_row(9'd2, 3 * SW, 16'h0100, "fill_skip");
        chk("rows_sat", 64'(rows_loaded), 64'd2);
        do_fetch(11'd2, 64'h000A_000B_0112_0113, "slide");
        chk("no_ferr2", 64'(fetch_err), 64'd0);

`ifdef RESCALE_NF_EDGE_CLAMP_EN
        do_fetch(11'd7, 64'h000F_000F_0117_0117, "edge7");
        do_fetch(11'h7FF, 64'h0008_0008_0110_0110, "edge_m1");
        chk("ferr_clamp", 64'(fetch_err), 64'd0);
`else
        do_fetch(11'd7, 64'h000F_0000_0117_0000, "edge7");
        chk("ferr_range", 64'(fetch_err), 64'd1);
        do_fetch(11'h7FF, 64'h0000_0008_0000_0110, "edge_m1");
`endif

        chk("row_err0", 64'(row_err), 64'd0);
        @(negedge clock);
        fill_req    = 1'b1;
        row_to_wait = 9'd0;
        @(negedge clock);
        fill_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'h0200 + 16'(i);
            s_tlast  = (i == 5);
            @(negedge clock);
        end
        s_tlast = 1'b0;
        chk("row_err1", 64'(row_err), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_tready", 64'(s_tready), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_rows", 64'(rows_loaded), 64'd0);
        chk("ar_errs", {62'd0, fetch_err, row_err}, 64'd0);
        chk("ar_nb", {neighbor0, neighbor1, neighbor2, neighbor3}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("post_tready", 64'(s_tready), 64'd0);
        chk("post_done", 64'(fill_done), 64'd0);
        s_tvalid = 1'b0;

        fetch_req = 1'b1;
        @(negedge clock);
        fetch_req = 1'b0;
        chk("ferr_idle", 64'(fetch_err), 64'd1);
        @(negedge clock);
        chk("ferr_idle_nv", 64'(neighbor_valid), 64'd0);

        @(negedge clock);
        fill_req    = 1'b1;
        row_to_wait = 9'd1;
        @(negedge clock);
        fill_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'h0300 + 16'(i);
            @(negedge clock);
        end
        s_tvalid    = 1'b0;
        frame_start = 1'b1;
        fill_req    = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        fill_req    = 1'b0;
        chk("fs_busy", 64'(busy), 64'd0);
        chk("fs_tready", 64'(s_tready), 64'd0);
        chk("fs_rows", 64'(rows_loaded), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("fs_no_done", 64'(fill_done), 64'd0);
        end
        chk("fs_row_err", 64'(row_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rescale_neighbor_fetch.md
RESCALE_NEIGHBOR_FETCH -- requirements
Module: rescale_neighbor_fetch

Interface
REQ-001 SHALL have parameter STAMP_W, default 8; stamp row width in pixels, range 2..1024.
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: s_tdata  in  16  stamp pixel, RGB565 {R[15:11],G[10:5],B[4:0]}; s_tvalid  in  1; s_tlast  in  1  last pixel of row; s_tready  out  1.
REQ-005 SHALL have ports: frame_start  in  1  pulse, clears loaded rows.
REQ-006 SHALL have ports: fill_req  in  1  pulse, skip then load one row; row_to_wait  in  9  rows to discard before loading, sampled with fill_req.
REQ-007 SHALL have ports: fill_done  out  1  one-cycle pulse when the row is loaded.
REQ-008 SHALL have ports: fetch_req  in  1  pulse; neighbor_offset  in  11  left column index, sampled with fetch_req.
REQ-009 SHALL have ports: neighbor0, neighbor1, neighbor2, neighbor3  out  16 each; neighbor_valid  out  1  one-cycle pulse.
REQ-010 SHALL have ports: busy  out  1  high outside IDLE/READY; rows_loaded  out  2  count 0..2; fetch_err  out  1  sticky; row_err  out  1  sticky.

Function
REQ-011 SHALL implement states IDLE, SKIP, FILL, READY, FETCH1, FETCH2.
REQ-012 SHALL store rows in two STAMP_W x 16 banks, top and bottom, selected by a 1-bit bank pointer.
REQ-013 fill_req in IDLE/READY SHALL go to SKIP if row_to_wait != 0, else FILL; ignored in other states.
REQ-014 s_tready SHALL be 1 only in SKIP and FILL; a beat transfers when s_tvalid & s_tready.
REQ-015 SKIP SHALL discard row_to_wait x STAMP_W beats, then enter FILL.
REQ-016 FILL SHALL write beats at column 0..STAMP_W-1 into the non-bottom bank; after beat STAMP_W-1 it SHALL toggle the bank pointer (old bottom becomes top), saturate-increment rows_loaded, pulse fill_done the next cycle, and enter READY.
REQ-017 s_tlast SHALL be checked on every beat; it is required exactly on column STAMP_W-1. A mismatch SHALL set row_err; the column count is not resynchronised.
REQ-018 fetch_req in READY with rows_loaded==2 SHALL enter FETCH1; in any other state or count it SHALL set fetch_err and be ignored.
REQ-019 In FETCH1 the block SHALL register column addresses c0=offset and c1=offset+1. In FETCH2 it SHALL drive: neighbor0=top[c0], neighbor1=top[c1], neighbor2=bottom[c0], neighbor3=bottom[c1]; pulse neighbor_valid; and return to READY.
REQ-020 fetch_req-to-neighbor_valid latency SHALL be exactly 2 cycles. Neighbor outputs SHALL hold their values until the next FETCH2.
REQ-021 Offset 0x7FF (i.e. -1) and offsets >= STAMP_W-1 SHALL be handled per REQ-028/REQ-029.
REQ-022 frame_start SHALL set rows_loaded=0 and enter IDLE from any state, aborting an in-progress SKIP/FILL with no fill_done. It SHALL take priority over a simultaneous fill_req or fetch_req.
REQ-023 A third and later fill SHALL overwrite the oldest bank (sliding two-row window).

Reset
REQ-024 While reset_n=0, the block SHALL be in IDLE with: s_tready=0, fill_done=0, neighbor_valid=0, busy=0, rows_loaded=0, fetch_err=0, row_err=0, neighbor0..3=0, bank pointer=0, and all counters=0.
REQ-025 Bank memory contents SHALL NOT be reset.
REQ-026 Reset asserted mid-operation SHALL abort immediately; beats presented afterwards are not consumed until a new fill_req.
REQ-027 Deassertion SHALL be synchronised internally, and the first active edge SHALL follow two clock cycles after release.

Configuration
REQ-028 With macro RESCALE_NF_EDGE_CLAMP_EN defined, c0 and c1 SHALL be clamped to [0, STAMP_W-1] (0x7FF maps to 0), and fetch_err SHALL NOT be set for range.
REQ-029 Without RESCALE_NF_EDGE_CLAMP_EN, any c0 or c1 outside [0, STAMP_W-1] SHALL output 0 for that neighbor and set fetch_err.

Verification
REQ-030 STAMP_W=8, frame_start, two fill_req with row_to_wait=0, pixels 0x0000..0x000F -> two fill_done pulses; rows_loaded=2; top = row 0 (0x0000..0x0007).
REQ-031 After REQ-030, fetch_req offset=3 -> 2 cycles later neighbor0..3 = 0x0003, 0x0004, 0x000B, 0x000C, with neighbor_valid a single pulse.
REQ-032 fill_req row_to_wait=2, stream 24 beats 0x0100..0x0117 -> first 16 dropped; new bottom = 0x0110..0x0117; previous bottom becomes top.
REQ-033 Clamp build: fetch offset=0x7FF -> neighbors = top[0], top[0], bottom[0], bottom[0]. Non-clamp build: offset=7 -> neighbor1=neighbor3=0, fetch_err=1.
REQ-034 Assert s_tlast on column 5 during FILL -> row_err=1. Then assert reset_n=0 mid-FILL -> s_tready=0 and all outputs at reset values in the same cycle.
